plb_tag_responder: RTL and testbench

- MEM/SRAM-protocol responder that implements the Protection Lookaside Buffer (PLB) answering side.
- Receives lookup reads whose address carries the supervisor physical address (SPA). Returns rdata 0x1 on hit, 0x0 on miss, one cycle after grant.
- Accepts fills as writes on the same port: the written address's page tag is installed.
- Sits between the MPT walker's PLB lookup master port and the walker's completion/fill logic.
- Small fully-associative tag store with round-robin replacement and a global flush.

---
 rtl/mpt_pkg.sv | 19 +
 rtl/plb_tag_cam.sv | 56 +++++
 rtl/plb_tag_responder.sv | 119 +++++++++++
 tb/tb_plb_tag_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpt_pkg.sv
// Shared MPT/PLB types and constants.
// Used by the PLB responder and the walker's lookup master.
package mpt_pkg;

  localparam int PLB_ADDR_W        = 64;
  localparam int PLB_PAGE_OFFSET_W = 12;
  localparam int PLB_TAG_W         = PLB_ADDR_W - PLB_PAGE_OFFSET_W;

  typedef logic [PLB_TAG_W-1:0] plb_tag_t;

  typedef struct packed {
    logic     valid;
    plb_tag_t tag;
  } plb_entry_t;

  localparam logic [63:0] PLB_HIT  = 64'h1;
  localparam logic [63:0] PLB_MISS = 64'h0;

endpackage

// File: rtl/plb_tag_cam.sv
// Fully-associative PLB tag store.
// Provides parallel match, lowest-free encoder and one write port.
module plb_tag_cam
  import mpt_pkg::*;
#(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  plb_tag_t           match_tag_i,
  output logic               hit_o,
  output logic [ENTRIES-1:0] hit_oh_o,
  output logic               free_o,
  output logic [IDX_W-1:0]   free_idx_o,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  plb_tag_t           wtag_i
);

  plb_entry_t ent_q [ENTRIES];

  always_comb begin
    hit_oh_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_oh_o[i] = ent_q[i].valid &&
                    (ent_q[i].tag == match_tag_i);
    end
  end

  assign hit_o = |hit_oh_o;

  // Scan high to low so the lowest free index wins.
  always_comb begin
    free_o     = 1'b0;
    free_idx_o = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_o     = 1'b1;
        free_idx_o = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
    end else if (we_i) begin
      ent_q[waddr_i] <= '{valid: 1'b1, tag: wtag_i};
    end
  end

endmodule

// File: rtl/plb_tag_responder.sv
// PLB answering side: lookup/fill over a MEM-style port.
// One-cycle response, round-robin replacement, global flush.
module plb_tag_responder
  import mpt_pkg::*;
#(
  parameter  int PLB_ENTRIES       = 4,
  parameter  int PAGE_OFFSET_WIDTH = PLB_PAGE_OFFSET_W,
  parameter  int MEM_DATA_WIDTH    = 64,
  parameter  int MEM_ADDR_WIDTH    = PLB_ADDR_W,
  localparam int IDX_W             = $clog2(PLB_ENTRIES),
  localparam int OCC_W             = IDX_W + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        plb_slave_mem_req,
  output logic                        plb_slave_mem_gnt,
  output logic                        plb_slave_mem_valid,
  input  logic [MEM_ADDR_WIDTH-1:0]   plb_slave_mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]   plb_slave_mem_rdata,
  input  logic [MEM_DATA_WIDTH-1:0]   plb_slave_mem_wdata,
  input  logic                        plb_slave_mem_we,
  input  logic [MEM_DATA_WIDTH/8-1:0] plb_slave_mem_be,
  output logic                        plb_slave_mem_error,
  input  logic                        plb_flush_i,
  output logic [OCC_W-1:0]            plb_occupancy_o
);

  logic                      gnt;
  plb_tag_t                  tag;
  logic                      hit;
  logic [PLB_ENTRIES-1:0]    hit_oh;
  logic                      free;
  logic [IDX_W-1:0]          free_idx;
  logic                      be_ok;
  logic                      install;
  logic [IDX_W-1:0]          waddr;

  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
  logic                      valid_q, valid_d;
  logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic unused_bits;
  assign unused_bits = ^{plb_slave_mem_wdata,
                         plb_slave_mem_addr[PAGE_OFFSET_WIDTH-1:0]};

  assign gnt = plb_slave_mem_req && !plb_flush_i && rst_ni;
  assign tag = plb_tag_t'(
    plb_slave_mem_addr[MEM_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH]);
  assign be_ok = &plb_slave_mem_be;

  // Existing tags are never duplicated; bad byte enables drop the fill.
  assign install = gnt && plb_slave_mem_we && be_ok && !(|hit_oh);
  assign waddr   = free ? free_idx : ptr_q;

  plb_tag_cam #(
    .ENTRIES (PLB_ENTRIES)
  ) u_cam (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (plb_flush_i),
    .match_tag_i (tag),
    .hit_o       (hit),
    .hit_oh_o    (hit_oh),
    .free_o      (free),
    .free_idx_o  (free_idx),
    .we_i        (install),
    .waddr_i     (waddr),
    .wtag_i      (tag)
  );

  always_comb begin
    ptr_d   = ptr_q;
    occ_d   = occ_q;
    valid_d = gnt;
    rdata_d = MEM_DATA_WIDTH'(PLB_MISS);
    err_d   = 1'b0;
    if (plb_flush_i) begin
      ptr_d = '0;
      occ_d = '0;
    end else if (install) begin
      if (free) begin
        occ_d = occ_q + OCC_W'(1);
      end else begin
        ptr_d = ptr_q + IDX_W'(1);
      end
    end
    if (gnt && !plb_slave_mem_we && hit) begin
      rdata_d = MEM_DATA_WIDTH'(PLB_HIT);
    end
    if (gnt && plb_slave_mem_we && !be_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign plb_slave_mem_gnt   = gnt;
  assign plb_slave_mem_valid = valid_q;
  assign plb_slave_mem_rdata = rdata_q;
  assign plb_slave_mem_error = err_q;
  assign plb_occupancy_o     = occ_q;

endmodule

// File: tb/tb_plb_tag_responder.sv
// Bench for plb_tag_responder: vector table, corner sequences,
// and random traffic against a page-set reference model.
module tb_plb_tag_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  logic        flush = 1'b0;
  logic        gnt;
  logic        valid;
  logic [63:0] rdata;
  logic        error;
  logic [2:0]  occ;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plb_tag_responder dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .plb_slave_mem_req   (req),
    .plb_slave_mem_gnt   (gnt),
    .plb_slave_mem_valid (valid),
    .plb_slave_mem_addr  (addr),
    .plb_slave_mem_rdata (rdata),
    .plb_slave_mem_wdata (wdata),
    .plb_slave_mem_we    (we),
    .plb_slave_mem_be    (be),
    .plb_slave_mem_error (error),
    .plb_flush_i         (flush),
    .plb_occupancy_o     (occ)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle at negedge, check gnt there, response after posedge.
  task automatic cycle(input logic r, input logic w,
                       input logic [63:0] a, input logic [7:0] b,
                       input logic f, input logic e_gnt,
                       input logic e_valid, input logic [63:0] e_rd,
                       input logic e_err, input logic [2:0] e_occ);
    @(negedge clk);
    req = r; we = w; addr = a; be = b; flush = f;
    wdata = {$urandom, $urandom};
    #1 chk("gnt", gnt, e_gnt);
    @(posedge clk);
    #1;
    chk("valid", valid, e_valid);
    chk("rdata", rdata, e_rd);
    chk("error", error, e_err);
    chk("occupancy", occ, e_occ);
  endtask

  // Reset with a fill request pending: it must be neither granted nor answered.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; we = 1'b1;
    addr = 64'h9000_0000; be = 8'hFF; flush = 1'b0;
    #1 chk("rst_gnt", gnt, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_error", error, 1'b0);
    chk("rst_occ", occ, 3'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0; we = 1'b0;
  endtask

  // Reference model: a set of resident pages plus a replacement pointer.
  logic        mv [4];
  logic [51:0] mt [4];
  int          mptr;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
    end
    mptr = 0;
  endtask

  task automatic model_step(input logic r, input logic w,
                            input logic [63:0] a, input logic [7:0] b,
                            input logic f, output logic e_gnt,
                            output logic e_valid, output logic [63:0] e_rd,
                            output logic e_err, output logic [2:0] e_occ);
    logic [51:0] t;
    bit present;
    int slot;
    int cnt;
    e_gnt = r && !f;
    e_valid = e_gnt;
    e_rd = 64'h0;
    e_err = 1'b0;
    t = a[63:12];
    present = 0;
    for (int i = 0; i < 4; i++) if (mv[i] && mt[i] == t) present = 1;
    if (f) begin
      model_clear();
    end else if (e_gnt && !w) begin
      e_rd = present ? 64'h1 : 64'h0;
    end else if (e_gnt && b != 8'hFF) begin
      e_err = 1'b1;
    end else if (e_gnt && !present) begin
      slot = -1;
      for (int i = 3; i >= 0; i--) if (!mv[i]) slot = i;
      if (slot < 0) begin
        slot = mptr;
        mptr = (mptr + 1) % 4;
      end
      mv[slot] = 1'b1;
      mt[slot] = t;
    end
    cnt = 0;
    for (int i = 0; i < 4; i++) if (mv[i]) cnt++;
    e_occ = 3'(cnt);
  endtask

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] rd;
    logic        err;
    logic [2:0]  occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic w, input logic [63:0] a,
                             input logic [7:0] b, input logic [63:0] rd,
                             input logic e, input logic [2:0] o);
    vec_t x;
    x.we = w; x.addr = a; x.be = b; x.rd = rd; x.err = e; x.occ = o;
    return x;
  endfunction

  initial begin
    logic        r, w, f, eg, ev, ee;
    logic [63:0] a, er;
    logic [7:0]  b;
    logic [2:0]  eo;

    tbl.push_back(v(0, 64'h8000_1234, 8'h00, 64'h0, 0, 3'd0));
    tbl.push_back(v(1, 64'h8000_1000, 8'hFF, 64'h0, 0, 3'd1));
    tbl.push_back(v(0, 64'h8000_1FFC, 8'h00, 64'h1, 0, 3'd1));
    tbl.push_back(v(1, 64'h0000_2000, 8'hFF, 64'h0, 0, 3'd2));
    tbl.push_back(v(1, 64'h0000_3000, 8'hFF, 64'h0, 0, 3'd3));
    tbl.push_back(v(1, 64'h0000_4000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(1, 64'h0000_5000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h8000_1000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_2000, 8'h0F, 64'h1, 0, 3'd4));
    tbl.push_back(v(1, 64'h0000_2ABC, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(1, 64'h0000_6000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_2000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_3000, 8'hFF, 64'h1, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_6000, 8'hFF, 64'h1, 0, 3'd4));
    tbl.push_back(v(1, 64'h0000_7000, 8'h0F, 64'h0, 1, 3'd4));
    tbl.push_back(v(0, 64'h0000_7000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_5000, 8'hFF, 64'h1, 0, 3'd4));
    tbl.push_back(v(1, 64'h0000_7000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_3000, 8'hFF, 64'h0, 0, 3'd4));
    tbl.push_back(v(0, 64'h0000_4000, 8'hFF, 64'h1, 0, 3'd4));

    do_reset();
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].we, tbl[i].addr, tbl[i].be, 1'b0,
            1'b1, 1'b1, tbl[i].rd, tbl[i].err, tbl[i].occ);
    end

    // Lookup granted right before a flush keeps its pre-flush hit.
    cycle(1'b1, 1'b0, 64'h0000_4000, 8'hFF, 1'b0,
          1'b1, 1'b1, 64'h1, 1'b0, 3'd4);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 64'h0000_4000; flush = 1'b1;
    #1;
    chk("flush_gnt", gnt, 1'b0);
    chk("flush_prev_valid", valid, 1'b1);
    chk("flush_prev_rdata", rdata, 64'h1);
    @(posedge clk);
    #1;
    chk("flush_valid", valid, 1'b0);
    chk("flush_occ", occ, 3'd0);
    cycle(1'b1, 1'b0, 64'h0000_4000, 8'hFF, 1'b0,
          1'b1, 1'b1, 64'h0, 1'b0, 3'd0);
    cycle(1'b0, 1'b0, 64'h0000_4000, 8'hFF, 1'b0,
          1'b0, 1'b0, 64'h0, 1'b0, 3'd0);

    // Reset with a populated table empties it.
    cycle(1'b1, 1'b1, 64'h0000_8000, 8'hFF, 1'b0,
          1'b1, 1'b1, 64'h0, 1'b0, 3'd1);
    do_reset();
    cycle(1'b1, 1'b0, 64'h0000_8000, 8'hFF, 1'b0,
          1'b1, 1'b1, 64'h0, 1'b0, 3'd0);

    model_clear();
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(0, 7) != 0);
      w = $urandom_range(0, 1) == 1;
      f = ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      a = 64'h8000_0000 + (64'($urandom_range(0, 6)) << 12) +
          64'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) a[40] = 1'b1;
      model_step(r, w, a, b, f, eg, ev, er, ee, eo);
      cycle(r, w, a, b, f, eg, ev, er, ee, eo);
    end

    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
